// File: rtl/bus_mmapper_pkg.sv
// -----------------------------------------------------------------------------
// bus_mmapper_pkg
// Shared types and constants for the pCPU bus memory mapper.
//   - state_e    : mapper FSM state encoding (2 bits)
//   - NSLAVE     : number of responder regions
//   - DW         : bus data/address width
//   - SPO_W      : width of the concatenated responder read-data bus
//   - onehot_idx : converts a one-hot responder select to its index
// -----------------------------------------------------------------------------
package bus_mmapper_pkg;

  localparam int NSLAVE = 4;
  localparam int DW     = 32;
  localparam int SPO_W  = NSLAVE * DW;
  localparam int SEL_W  = $clog2(NSLAVE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_e;

  // Index of the set bit in a one-hot vector; 0 when no bit is set.
  function automatic logic [SEL_W-1:0] onehot_idx(input logic [NSLAVE-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      if (oh[k]) idx = SEL_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// -----------------------------------------------------------------------------
// bus_addr_decode
// Combinational address decoder for the four responder regions. Region k hits
// when (address & MASK_k) == BASE_k; the lowest-numbered region wins when
// regions overlap.
// Ports:
//   i_a    in  32 : request address
//   o_hit  out 4  : one-hot selected region (priority encoded)
//   o_miss out 1  : no region matches
// -----------------------------------------------------------------------------
module bus_addr_decode
  import bus_mmapper_pkg::*;
#(
  parameter logic [DW-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [DW-1:0] S0_MASK = 32'hF000_0000,
  parameter logic [DW-1:0] S1_BASE = 32'h1000_0000,
  parameter logic [DW-1:0] S1_MASK = 32'hF000_0000,
  parameter logic [DW-1:0] S2_BASE = 32'h2000_0000,
  parameter logic [DW-1:0] S2_MASK = 32'hFF00_0000,
  parameter logic [DW-1:0] S3_BASE = 32'h3000_0000,
  parameter logic [DW-1:0] S3_MASK = 32'hFF00_0000
) (
  input  logic [DW-1:0]     i_a,
  output logic [NSLAVE-1:0] o_hit,
  output logic              o_miss
);

  logic [NSLAVE-1:0] w_raw;

  assign w_raw[0] = ((i_a & S0_MASK) == S0_BASE);
  assign w_raw[1] = ((i_a & S1_MASK) == S1_BASE);
  assign w_raw[2] = ((i_a & S2_MASK) == S2_BASE);
  assign w_raw[3] = ((i_a & S3_MASK) == S3_BASE);

  // NOTE: o_hit gets a default before the priority chain so every path
  // assigns it and no latch is inferred.
  always_comb begin
    o_hit = '0;
    if      (w_raw[0]) o_hit = 4'b0001;
    else if (w_raw[1]) o_hit = 4'b0010;
    else if (w_raw[2]) o_hit = 4'b0100;
    else if (w_raw[3]) o_hit = 4'b1000;
  end

  assign o_miss = ~|w_raw;

endmodule

// File: rtl/bus_mmapper.sv
// -----------------------------------------------------------------------------
// bus_mmapper
// Single-initiator, four-responder memory mapper on the pCPU system bus.
// Decodes the granted request, issues a one-cycle strobe to the selected
// responder, waits (bounded by TIMEOUT) for its ready, and returns read data,
// zero for a write, or ERR_DATA on an unmapped address or timeout.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   a, d, we, rd      : request address, write data, write/read strobes
//   spo, ready        : returned data, idle/done flag (0 = busy)
//   s_a, s_d          : registered address/write data shared by responders
//   s_we, s_rd        : one-hot responder write/read strobes
//   s_spo, s_ready    : responder read data (slice k = responder k), readies
//   err_cnt, err_addr : saturating error count, address of most recent error
// -----------------------------------------------------------------------------
module bus_mmapper
  import bus_mmapper_pkg::*;
#(
  parameter logic [DW-1:0] S0_BASE  = 32'h0000_0000,
  parameter logic [DW-1:0] S0_MASK  = 32'hF000_0000,
  parameter logic [DW-1:0] S1_BASE  = 32'h1000_0000,
  parameter logic [DW-1:0] S1_MASK  = 32'hF000_0000,
  parameter logic [DW-1:0] S2_BASE  = 32'h2000_0000,
  parameter logic [DW-1:0] S2_MASK  = 32'hFF00_0000,
  parameter logic [DW-1:0] S3_BASE  = 32'h3000_0000,
  parameter logic [DW-1:0] S3_MASK  = 32'hFF00_0000,
  parameter int            TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     d,
  input  logic              we,
  input  logic              rd,
  output logic [DW-1:0]     spo,
  output logic              ready,
  output logic [DW-1:0]     s_a,
  output logic [DW-1:0]     s_d,
  output logic [NSLAVE-1:0] s_we,
  output logic [NSLAVE-1:0] s_rd,
  input  logic [SPO_W-1:0]  s_spo,
  input  logic [NSLAVE-1:0] s_ready,
  output logic [7:0]        err_cnt,
  output logic [DW-1:0]     err_addr
);

  // Last timer value before the wait is declared timed out.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic              r_is_wr;
  logic [DW-1:0]     r_addr;
  logic [7:0]        r_timer;

  logic [NSLAVE-1:0] w_hit;
  logic              w_miss;
  logic              w_strobe;
  logic [DW-1:0]     w_rdata;

  bus_addr_decode #(
    .S0_BASE (S0_BASE), .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE), .S1_MASK (S1_MASK),
    .S2_BASE (S2_BASE), .S2_MASK (S2_MASK),
    .S3_BASE (S3_BASE), .S3_MASK (S3_MASK)
  ) u_decode (
    .i_a    (a),
    .o_hit  (w_hit),
    .o_miss (w_miss)
  );

  assign w_strobe = rd | we;
  assign w_rdata  = s_spo[r_sel*DW +: DW];

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, and every register (no memories here) has an
  // asynchronous reset value so an abort leaves the bus quiet immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_is_wr  <= 1'b0;
      r_addr   <= '0;
      r_timer  <= '0;
      ready    <= 1'b1;
      spo      <= '0;
      s_a      <= '0;
      s_d      <= '0;
      s_we     <= '0;
      s_rd     <= '0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Strobes are only sampled here, so anything arriving while busy
          // is dropped rather than queued.
          if (w_strobe) begin
            r_addr  <= a;
            r_is_wr <= we;
            ready   <= 1'b0;
            if (!w_miss) begin
              r_sel   <= onehot_idx(w_hit);
              s_a     <= a;
              s_d     <= d;
              // Write wins when both strobes arrive together.
              s_we    <= we ? w_hit : '0;
              s_rd    <= we ? '0 : w_hit;
              r_state <= REQ;
            end else begin
              r_state <= ERR;
            end
          end
        end

        REQ: begin
          s_we    <= '0;
          s_rd    <= '0;
          r_timer <= '0;
          r_state <= WAIT;
        end

        WAIT: begin
          if (s_ready[r_sel]) begin
            spo     <= r_is_wr ? '0 : w_rdata;
            ready   <= 1'b1;
            r_state <= IDLE;
          end else if (r_timer == TMO_LAST) begin
            spo      <= ERR_DATA;
            err_addr <= r_addr;
            err_cnt  <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            ready    <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        ERR: begin
          spo      <= ERR_DATA;
          err_addr <= r_addr;
          err_cnt  <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
          ready    <= 1'b1;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
